// File: rtl/hht_pkg.sv
// hht_pkg: shared types, defaults and address decode for the HHT memory responder.
package hht_pkg;
    localparam int unsigned MISS_DATA_DEF = 99999;
    typedef enum logic {IDLE, CLEAR} state_t;
    // Widened to 64 bits so base+depth cannot wrap for any practical address width
    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] depth);
        return addr >= base && addr < base + depth;
    endfunction
endpackage

// File: rtl/hht_mem_rport.sv
// hht_mem_rport: one registered read stage with range check and write-first bypass.
module hht_mem_rport
    import hht_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] MISS_DATA = DATA_W'(MISS_DATA_DEF),
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              rd,
    input  logic              clearing,
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              err
);
    logic              hit;
    logic [DATA_W-1:0] rdata;
    assign hit = addr_in_range(64'(addr), 64'(BASE_ADDR), 64'(DEPTH));
    assign idx = IDX_W'(addr - BASE_ADDR);
    always_comb rdata = (clearing || !hit) ? MISS_DATA : (wr_en && wr_idx == idx) ? wr_data : mem_data;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_out <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= rd;
            if (rd) begin
                data_out <= rdata;
                err      <= !clearing && !hit;
            end
        end
    end
endmodule

// File: rtl/hht_mem_responder.sv
// hht_mem_responder: dual read-port storage with CPU write port and zero-fill sequencer.
module hht_mem_responder
    import hht_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] MISS_DATA = DATA_W'(MISS_DATA_DEF)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              mem_init,
    output logic              busy,
    input  logic              WR,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              RD,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] dataOut1,
    output logic              valid1,
    output logic              err1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] dataOut2,
    output logic              valid2,
    output logic              err2
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state, state_nx;
    logic [IDX_W-1:0]  clr_ptr, idx1, idx2, cpu_idx, widx;
    logic              cpu_we, we, last;
    logic [DATA_W-1:0] wdata;
    assign cpu_idx = IDX_W'(cpu_addr - BASE_ADDR);
    assign cpu_we  = WR && state == IDLE && addr_in_range(64'(cpu_addr), 64'(BASE_ADDR), 64'(DEPTH));
    assign last    = clr_ptr == IDX_W'(DEPTH - 1);
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= (state == CLEAR && !last) ? clr_ptr + IDX_W'(1) : '0;
        end
    end
    always_comb state_nx = (state == IDLE) ? (mem_init ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    always_comb begin
        busy  = state == CLEAR;
        we    = busy || cpu_we;
        widx  = busy ? clr_ptr : cpu_idx;
        wdata = busy ? '0 : cpu_wdata;
    end
    always_ff @(posedge Clk) begin
        if (we) mem[widx] <= wdata;
    end
    hht_mem_rport #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE_ADDR), .MISS_DATA(MISS_DATA), .IDX_W(IDX_W)
    ) u_rport1 (
        .Clk(Clk), .Rst(Rst), .rd(RD), .clearing(busy), .addr(addr1), .idx(idx1),
        .mem_data(mem[idx1]), .wr_en(cpu_we), .wr_idx(cpu_idx), .wr_data(cpu_wdata),
        .data_out(dataOut1), .valid(valid1), .err(err1)
    );
    hht_mem_rport #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE_ADDR), .MISS_DATA(MISS_DATA), .IDX_W(IDX_W)
    ) u_rport2 (
        .Clk(Clk), .Rst(Rst), .rd(RD), .clearing(busy), .addr(addr2), .idx(idx2),
        .mem_data(mem[idx2]), .wr_en(cpu_we), .wr_idx(cpu_idx), .wr_data(cpu_wdata),
        .data_out(dataOut2), .valid(valid2), .err(err2)
    );
endmodule

// File: tb/tb_hht_mem_responder.sv
// tb_hht_mem_responder: directed checks of reads, bypass, decode and zero-fill.
module tb_hht_mem_responder;
    logic        Clk, Rst, mem_init, WR, RD;
    logic [31:0] cpu_addr, cpu_wdata, addr1, addr2;
    logic [31:0] d1, d2, b_d1, b_d2;
    logic        busy, v1, e1, v2, e2, b_busy, b_v1, b_e1, b_v2, b_e2;
    logic [31:0] exp_mem [512];
    logic [31:0] vals [16] = '{7, 93, 68, 21, 50, 11, 82, 45, 3, 76, 29, 64, 18, 90, 57, 34};
    int          n_chk = 0, n_fail = 0, cnt;

    hht_mem_responder u_dut (
        .Clk(Clk), .Rst(Rst), .mem_init(mem_init), .busy(busy), .WR(WR), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .RD(RD), .addr1(addr1), .dataOut1(d1), .valid1(v1), .err1(e1),
        .addr2(addr2), .dataOut2(d2), .valid2(v2), .err2(e2)
    );
    hht_mem_responder #(.BASE_ADDR(32'd4)) u_b4 (
        .Clk(Clk), .Rst(Rst), .mem_init(mem_init), .busy(b_busy), .WR(WR), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .RD(RD), .addr1(addr1), .dataOut1(b_d1), .valid1(b_v1), .err1(b_e1),
        .addr2(addr2), .dataOut2(b_d2), .valid2(b_v2), .err2(b_e2)
    );

    initial begin
        Clk = 1'b0;
        #40;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        WR = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        step();
        WR = 1'b0;
        if (a < 512) exp_mem[a] = d;
    endtask

    initial begin
        Rst = 1'b1;
        #35 Rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_valid2", v2, 0);
        chk("rst_err1", e1, 0);
        chk("rst_err2", e2, 0);
        chk("rst_data1", d1, 0);
        chk("rst_data2", d2, 0);
        chk("rst_b4_busy", b_busy, 0);
        {mem_init, WR, RD} = '0;
        {cpu_addr, cpu_wdata, addr1, addr2} = '0;
        step();
        step();
        Rst = 1'b1;
        step();
        for (int i = 0; i < 16; i++) wr(2 + i, vals[i]);
        RD = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr2 = 2 + i;
            step();
            chk("load_valid2", v2, 1);
            chk("load_data2", d2, vals[i]);
        end
        RD = 1'b0;
        step();
        chk("idle_valid2", v2, 0);
        chk("idle_hold2", d2, 34);
        for (int a = 180; a < 410; a++) wr(a, a * 7 + 3);
        wr(511, 4242);
        RD = 1'b1;
        for (int i = 0; i < 230; i++) begin
            addr1 = 180 + i;
            addr2 = 2 + (i % 16);
            step();
            chk("dual_data1", d1, exp_mem[180 + i]);
            chk("dual_data2", d2, exp_mem[2 + (i % 16)]);
            chk("dual_valid", {v1, v2, e1, e2}, 4'b1100);
        end
        addr1 = 517;
        addr2 = 3;
        step();
        chk("unmap_data1", d1, 99999);
        chk("unmap_err1", {v1, e1}, 2'b11);
        chk("map_data2", d2, 93);
        chk("b4_unmap_data2", b_d2, 99999);
        chk("b4_unmap_err2", {b_v2, b_e2}, 2'b11);
        addr1 = 511;
        addr2 = 4;
        step();
        chk("top_word1", {e1, d1}, {1'b0, 32'd4242});
        chk("b4_base_data2", {b_e2, b_d2}, {1'b0, 32'd68});
        addr1 = 512;
        step();
        chk("past_end1", {e1, d1}, {1'b1, 32'd99999});
        wr(88, 888);
        WR = 1'b1;
        cpu_addr = 126;
        cpu_wdata = 55;
        addr1 = 126;
        addr2 = 126;
        step();
        exp_mem[126] = 55;
        chk("bypass1", d1, 55);
        chk("bypass2", d2, 55);
        cpu_addr = 600;
        cpu_wdata = 77;
        addr1 = 88;
        addr2 = 600;
        step();
        WR = 1'b0;
        chk("unmap_wr_nobypass", d1, 888);
        chk("unmap_wr_read2", {e2, d2}, {1'b1, 32'd99999});
        addr2 = 126;
        step();
        chk("unmap_wr_kept", d1, 888);
        chk("bypass_stored", d2, 55);
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            mem_init = (cnt == 200);
            WR = (cnt % 50 == 0);
            cpu_addr = 5;
            cpu_wdata = 1234;
            addr1 = 17;
            addr2 = 600;
            step();
            chk("clr_data1", {v1, e1, d1}, {2'b10, 32'd99999});
            chk("clr_data2", {v2, e2, d2}, {2'b10, 32'd99999});
        end
        {WR, mem_init} = '0;
        chk("clr_busy_cycles", cnt, 512);
        for (int i = 0; i < 512; i++) exp_mem[i] = 0;
        for (int i = 0; i < 512; i++) begin
            addr1 = i;
            addr2 = 511 - i;
            step();
            chk("cleared1", d1, exp_mem[i]);
            chk("cleared2", d2, exp_mem[511 - i]);
        end
        wr(50, 5);
        wr(300, 42);
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        chk("refill_busy", busy, 1);
        repeat (100) step();
        Rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid1", v1, 0);
        #3 Rst = 1'b1;
        addr1 = 50;
        addr2 = 300;
        step();
        chk("partial_cleared", {v1, d1}, {1'b1, 32'd0});
        chk("partial_kept", {v2, d2}, {1'b1, 32'd42});
        step();
        chk("post_abort_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
